// File: rtl/vector_pkg.sv
// Shared constants for the vector display output path.
// MCP4822 command nibbles: {sel, unused, ga_n, shdn_n}.
package vector_pkg;

  localparam logic [3:0] DAC_CMD_A     = 4'b0011;
  localparam logic [3:0] DAC_CMD_B     = 4'b1011;
  localparam int         DAC_WORD_BITS = 16;

endpackage

// File: rtl/dac_spi_shifter.sv
// SPI mode-0 serialiser for one DAC command word, MSB first.
// Every bit spends SCLK_DIV cycles with sclk low, then SCLK_DIV cycles with sclk high.
module dac_spi_shifter
  import vector_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [DAC_WORD_BITS-1:0] word,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     shift_done
);

  localparam int              HW        = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [HW-1:0]   HALF_LAST = HW'(SCLK_DIV - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(DAC_WORD_BITS - 1);

  logic [DAC_WORD_BITS-1:0] shift_q, shift_d;
  logic [HW-1:0]            half_q, half_d;
  logic [3:0]               bit_q, bit_d;
  logic                     sclk_q, sclk_d;
  logic                     mosi_q, mosi_d;
  logic                     active_q, active_d;
  logic                     halfEnd;

  assign halfEnd    = (half_q == HALF_LAST);
  assign shift_done = active_q && sclk_q && halfEnd && (bit_q == BIT_LAST);
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;

  // The next bit is presented on the same edge sclk falls, so mosi is settled well before the rise.
  always_comb begin
    shift_d  = shift_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    active_d = active_q;
    if (load) begin
      active_d = 1'b1;
      shift_d  = word;
      half_d   = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      mosi_d   = word[DAC_WORD_BITS-1];
    end else if (active_q) begin
      if (!halfEnd) begin
        half_d = half_q + HW'(1);
      end else begin
        half_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            mosi_d   = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[DAC_WORD_BITS-2:0], 1'b0};
            mosi_d  = shift_q[DAC_WORD_BITS-2];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// Sends X then Y to a dual-channel MCP4822 and pulses LDAC so both outputs move together.
// The beam must not skew, so LDAC is only ever pulsed after both words are complete.
module dac_spi_driver
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int DAC_BITS    = 12,
  parameter int SCLK_DIV    = 4,
  parameter int CS_GAP      = 2,
  parameter int LDAC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] x_in,
  input  logic [OUT_WIDTH-1:0] y_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 ldac_n
);

  localparam int DATA_W  = DAC_WORD_BITS - 4;
  localparam int PAD     = (DAC_BITS - OUT_WIDTH) + (DATA_W - DAC_BITS);
  localparam int CNT_MAX = (CS_GAP > LDAC_CYCLES) ? CS_GAP : LDAC_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LATCH} state_e;

  state_e                   state_q;
  logic [OUT_WIDTH-1:0]     y_q;
  logic [CW-1:0]            cnt_q;
  logic                     cs_n_q, ldac_n_q, busy_q, done_q;
  logic                     shiftLoad, shiftDone;
  logic [DAC_WORD_BITS-1:0] wordA, wordB, loadWord;

  // X is captured by the shifter itself on the start edge; only Y needs holding here.
  assign wordA     = {DAC_CMD_A, (DATA_W'(x_in) << PAD)};
  assign wordB     = {DAC_CMD_B, (DATA_W'(y_q) << PAD)};
  assign loadWord  = (state_q == IDLE) ? wordA : wordB;
  assign shiftLoad = ((state_q == IDLE) && start) || ((state_q == GAP_A) && (cnt_q == '0));

  dac_spi_shifter #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (shiftLoad),
    .word       (loadWord),
    .sclk       (sclk),
    .mosi       (mosi),
    .shift_done (shiftDone)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign cs_n   = cs_n_q;
  assign ldac_n = ldac_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      cnt_q    <= '0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            y_q     <= y_in;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT_A;
          end
        end
        SHIFT_A: begin
          if (shiftDone) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= CW'(CS_GAP - 1);
            state_q <= GAP_A;
          end
        end
        GAP_A: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b0;
            state_q <= SHIFT_B;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SHIFT_B: begin
          if (shiftDone) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= CW'(CS_GAP - 1);
            state_q <= GAP_B;
          end
        end
        GAP_B: begin
          if (cnt_q == '0) begin
            ldac_n_q <= 1'b0;
            cnt_q    <= CW'(LDAC_CYCLES - 1);
            state_q  <= LATCH;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        LATCH: begin
          if (cnt_q == '0) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: a default-parameter instance and a fastest-timing instance,
// with an SPI monitor that rebuilds transmitted words and watches the bus rules.
module tb_dac_spi_driver;

  localparam int DIV0 = 4, GAP0 = 2, LD0 = 2;
  localparam int DIV1 = 1, GAP1 = 1, LD1 = 1;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] wa;
    logic [15:0] wb;
    bit          toggle;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstIn[2];
  logic [7:0] xIn[2];
  logic [7:0] yIn[2];
  logic       startIn[2];
  logic       busyW[2], doneW[2], sclkW[2], mosiW[2], csW[2], ldacW[2];

  int tests = 0;
  int failures = 0;

  int          bitsCnt[2], partial[2], ldacRun[2], ldacPulses[2], ldacLen[2];
  int          doneCnt[2], stabViol[2], overlapViol[2];
  logic        prevSclk[2], prevMosi[2], prevCs[2];
  logic [15:0] shreg[2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  dac_spi_driver #(
    .OUT_WIDTH(8), .DAC_BITS(12), .SCLK_DIV(DIV0), .CS_GAP(GAP0), .LDAC_CYCLES(LD0)
  ) dut0 (
    .clk(clk), .rst(rstIn[0]), .x_in(xIn[0]), .y_in(yIn[0]), .start(startIn[0]),
    .busy(busyW[0]), .done(doneW[0]), .sclk(sclkW[0]), .mosi(mosiW[0]),
    .cs_n(csW[0]), .ldac_n(ldacW[0])
  );

  dac_spi_driver #(
    .OUT_WIDTH(8), .DAC_BITS(12), .SCLK_DIV(DIV1), .CS_GAP(GAP1), .LDAC_CYCLES(LD1)
  ) dut1 (
    .clk(clk), .rst(rstIn[1]), .x_in(xIn[1]), .y_in(yIn[1]), .start(startIn[1]),
    .busy(busyW[1]), .done(doneW[1]), .sclk(sclkW[1]), .mosi(mosiW[1]),
    .cs_n(csW[1]), .ldac_n(ldacW[1])
  );

  // Bus monitor on the falling clock edge, away from where the DUT updates its outputs.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!csW[k] && sclkW[k] && !prevSclk[k]) begin
        shreg[k] = {shreg[k][14:0], mosiW[k]};
        bitsCnt[k]++;
      end
      if (sclkW[k] && ((mosiW[k] != prevMosi[k]) || csW[k])) stabViol[k]++;
      if (csW[k] && !prevCs[k]) begin
        if (bitsCnt[k] == 16) begin
          if (k == 0) q0.push_back(shreg[k]);
          else q1.push_back(shreg[k]);
        end else begin
          partial[k]++;
        end
        bitsCnt[k] = 0;
      end
      if (!ldacW[k] && !csW[k]) overlapViol[k]++;
      if (!ldacW[k]) begin
        ldacRun[k]++;
      end else if (ldacRun[k] != 0) begin
        ldacPulses[k]++;
        ldacLen[k] = ldacRun[k];
        ldacRun[k] = 0;
      end
      if (doneW[k]) doneCnt[k]++;
      prevSclk[k] = sclkW[k];
      prevMosi[k] = mosiW[k];
      prevCs[k]   = csW[k];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] popWord(input int k);
    if (k == 0) return (q0.size() > 0) ? {16'h0, q0.pop_front()} : 32'hDEAD_BEEF;
    return (q1.size() > 0) ? {16'h0, q1.pop_front()} : 32'hDEAD_BEEF;
  endfunction

  function automatic int queueSize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int expLatency(input int k);
    return (k == 0) ? (2*32*DIV0 + 2*GAP0 + LD0 + 1) : (2*32*DIV1 + 2*GAP1 + LD1 + 1);
  endfunction

  // One start pulse; lat counts falling edges from the start cycle until done is seen.
  task automatic applyStimulus(input int k, input logic [7:0] x, input logic [7:0] y,
                               input bit toggle, output int lat);
    @(negedge clk);
    xIn[k] = x;
    yIn[k] = y;
    startIn[k] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      startIn[k] = 1'b0;
      if (toggle) begin
        xIn[k] = 8'($urandom);
        yIn[k] = 8'($urandom);
      end
    end while (doneW[k] !== 1'b1 && lat < 2000);
  endtask

  task automatic waitDone(input int k, output int n);
    n = 0;
    while (doneW[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  vec_t vecs[4];
  int   lat, n, pulsesBefore, doneBefore, partialBefore;

  initial begin
    vecs[0] = '{x: 8'hA5, y: 8'h3C, wa: 16'h3A50, wb: 16'hB3C0, toggle: 1'b0};
    vecs[1] = '{x: 8'h00, y: 8'hFF, wa: 16'h3000, wb: 16'hBFF0, toggle: 1'b1};
    vecs[2] = '{x: 8'hFF, y: 8'h00, wa: 16'h3FF0, wb: 16'hB000, toggle: 1'b1};
    vecs[3] = '{x: 8'h81, y: 8'h7E, wa: 16'h3810, wb: 16'hB7E0, toggle: 1'b0};

    for (int k = 0; k < 2; k++) begin
      rstIn[k] = 1'b1; xIn[k] = '0; yIn[k] = '0; startIn[k] = 1'b0;
      bitsCnt[k] = 0; partial[k] = 0; ldacRun[k] = 0; ldacPulses[k] = 0; ldacLen[k] = 0;
      doneCnt[k] = 0; stabViol[k] = 0; overlapViol[k] = 0;
      prevSclk[k] = 1'b0; prevMosi[k] = 1'b0; prevCs[k] = 1'b1; shreg[k] = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset cs_n[%0d]", k), 32'(csW[k]), 32'd1);
      checkOutput($sformatf("reset ldac_n[%0d]", k), 32'(ldacW[k]), 32'd1);
      checkOutput($sformatf("reset sclk[%0d]", k), 32'(sclkW[k]), 32'd0);
      checkOutput($sformatf("reset mosi[%0d]", k), 32'(mosiW[k]), 32'd0);
      checkOutput($sformatf("reset busy[%0d]", k), 32'(busyW[k]), 32'd0);
      checkOutput($sformatf("reset done[%0d]", k), 32'(doneW[k]), 32'd0);
      rstIn[k] = 1'b0;
    end

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        pulsesBefore = ldacPulses[k];
        applyStimulus(k, vecs[i].x, vecs[i].y, vecs[i].toggle, lat);
        @(negedge clk);
        checkOutput($sformatf("latency v%0d d%0d", i, k), 32'(lat), 32'(expLatency(k)));
        checkOutput($sformatf("wordA v%0d d%0d", i, k), popWord(k), {16'h0, vecs[i].wa});
        checkOutput($sformatf("wordB v%0d d%0d", i, k), popWord(k), {16'h0, vecs[i].wb});
        checkOutput($sformatf("extra words v%0d d%0d", i, k), 32'(queueSize(k)), 32'd0);
        checkOutput($sformatf("ldac pulses v%0d d%0d", i, k), 32'(ldacPulses[k] - pulsesBefore), 32'd1);
        checkOutput($sformatf("ldac length v%0d d%0d", i, k), 32'(ldacLen[k]), 32'((k == 0) ? LD0 : LD1));
      end
    end

    // start held high: the done cycle doubles as the next capture cycle.
    doneBefore = doneCnt[0];
    @(negedge clk);
    xIn[0] = 8'h12; yIn[0] = 8'h34; startIn[0] = 1'b1;
    @(negedge clk);
    waitDone(0, n);
    checkOutput("b2b first done busy", 32'(busyW[0]), 32'd0);
    @(negedge clk);
    checkOutput("b2b recapture busy", 32'(busyW[0]), 32'd1);
    n = 1;
    while (doneW[0] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    startIn[0] = 1'b0;
    checkOutput("b2b period", 32'(n), 32'(expLatency(0)));
    @(negedge clk);
    checkOutput("b2b stops after release", 32'(busyW[0]), 32'd0);
    checkOutput("b2b done count", 32'(doneCnt[0] - doneBefore), 32'd2);
    checkOutput("b2b word count", 32'(q0.size()), 32'd4);
    for (int j = 0; j < 2; j++) begin
      checkOutput($sformatf("b2b wordA %0d", j), popWord(0), 32'h3120);
      checkOutput($sformatf("b2b wordB %0d", j), popWord(0), 32'hB340);
    end

    // Reset in the middle of word A abandons the update without a latch pulse.
    pulsesBefore = ldacPulses[0];
    doneBefore = doneCnt[0];
    partialBefore = partial[0];
    @(negedge clk);
    xIn[0] = 8'hC3; yIn[0] = 8'h5A; startIn[0] = 1'b1;
    @(negedge clk);
    startIn[0] = 1'b0;
    repeat (69) @(negedge clk);
    rstIn[0] = 1'b1;
    @(negedge clk);
    checkOutput("midreset cs_n", 32'(csW[0]), 32'd1);
    checkOutput("midreset sclk", 32'(sclkW[0]), 32'd0);
    checkOutput("midreset busy", 32'(busyW[0]), 32'd0);
    checkOutput("midreset mosi", 32'(mosiW[0]), 32'd0);
    rstIn[0] = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("midreset ldac pulses", 32'(ldacPulses[0] - pulsesBefore), 32'd0);
    checkOutput("midreset done count", 32'(doneCnt[0] - doneBefore), 32'd0);
    checkOutput("midreset partial words", 32'(partial[0] - partialBefore), 32'd1);
    checkOutput("midreset full words", 32'(q0.size()), 32'd0);
    applyStimulus(0, 8'hC3, 8'h5A, 1'b0, lat);
    @(negedge clk);
    checkOutput("post-reset latency", 32'(lat), 32'(expLatency(0)));
    checkOutput("post-reset wordA", popWord(0), 32'h3C30);
    checkOutput("post-reset wordB", popWord(0), 32'hB5A0);

    // A start pulse while busy is neither accepted nor queued.
    doneBefore = doneCnt[0];
    @(negedge clk);
    xIn[0] = 8'h11; yIn[0] = 8'h22; startIn[0] = 1'b1;
    @(negedge clk);
    startIn[0] = 1'b0;
    repeat (49) @(negedge clk);
    xIn[0] = 8'hEE; yIn[0] = 8'hDD; startIn[0] = 1'b1;
    @(negedge clk);
    startIn[0] = 1'b0;
    waitDone(0, n);
    checkOutput("busy start timeout", 32'(doneW[0]), 32'd1);
    repeat (300) @(negedge clk);
    checkOutput("busy start done count", 32'(doneCnt[0] - doneBefore), 32'd1);
    checkOutput("busy start wordA", popWord(0), 32'h3110);
    checkOutput("busy start wordB", popWord(0), 32'hB220);
    checkOutput("busy start extra words", 32'(q0.size()), 32'd0);

    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("mosi stability d%0d", k), 32'(stabViol[k]), 32'd0);
      checkOutput($sformatf("ldac overlap d%0d", k), 32'(overlapViol[k]), 32'd0);
    end
    checkOutput("fast partial words", 32'(partial[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
